// File: rtl/mont_domain_encoder.sv
// Normal-to-Montgomery domain converter for ML-KEM coefficients (q = 3329, R = 2^16).
// Three-stage valid/ready pipeline computing a*R mod q, with polynomial frame-length checking.
module mont_domain_encoder #(
    parameter int N_COEFF = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        frame_err
);
    localparam int CNT_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_COEFF - 1);
    localparam logic [26:0] R2_MOD_Q = 27'd1353;
    localparam logic [15:0] Q_PRIME  = 16'd3327;
    localparam logic [28:0] Q29      = 29'd3329;
    localparam logic [12:0] Q13      = 13'd3329;

    // Final conditional subtract: u < 2q, so one subtraction lands in [0, q).
    function automatic logic [15:0] csub_q(input logic [12:0] u);
        csub_q = (u >= Q13) ? 16'(u - Q13) : 16'(u);
    endfunction

    logic        en;
    logic        vld_p1_q, last_p1_q;
    logic [26:0] t_p1_q;
    logic        vld_p2_q, last_p2_q;
    logic [26:0] t_p2_q;
    logic [15:0] m_p2_q;
    logic        vld_p3_q, last_p3_q;
    logic [15:0] data_p3_q;
    logic [28:0] sum_p2;
    logic [12:0] u_p2;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    assign en       = ~vld_p3_q | out_ready;
    assign in_ready = en;

    // Low 16 bits of the sum are zero by construction of m, so the shift is exact.
    assign sum_p2 = 29'(t_p2_q) + 29'(m_p2_q) * Q29;
    assign u_p2   = 13'(sum_p2 >> 16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            last_p2_q <= 1'b0;
            vld_p3_q  <= 1'b0;
            last_p3_q <= 1'b0;
            data_p3_q <= '0;
        end else if (en) begin
            // stage 1: capture input
            vld_p1_q  <= in_valid;
            last_p1_q <= in_last;
            // stage 2: Montgomery quotient
            vld_p2_q  <= vld_p1_q;
            last_p2_q <= last_p1_q;
            // stage 3: reduce and correct
            vld_p3_q  <= vld_p2_q;
            last_p3_q <= last_p2_q;
            data_p3_q <= csub_q(u_p2);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            t_p1_q <= 27'(in_data) * R2_MOD_Q;
            t_p2_q <= t_p1_q;
            m_p2_q <= 16'(t_p1_q[15:0] * Q_PRIME);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (in_valid && en) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
                if (!in_last) err_d = 1'b1;
            end else if (in_last) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign out_valid = vld_p3_q;
    assign out_data  = data_p3_q;
    assign out_last  = last_p3_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_mont_domain_encoder.sv
// Bench for mont_domain_encoder: known-value table, framing sequences, and a
// randomized backpressure run checked against an arithmetic scoreboard.
module tb_mont_domain_encoder;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_err;

    mont_domain_encoder #(.N_COEFF(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int out_cnt  = 0;
    bit bp_mode  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference: a*2^16 mod 3329 straight from the definition.
    function automatic logic [15:0] mont_ref(input logic [15:0] a);
        longint v;
        v = (longint'(a) * 65536) % 3329;
        return 16'(v);
    endfunction

    typedef struct packed { logic [15:0] d; logic l; } exp_t;
    exp_t exp_q[$];
    int   n_m   = 0;
    bit   err_m = 1'b0;
    bit   hold_v = 1'b0;
    logic [15:0] hold_d;
    logic hold_l;

    // Scoreboard and frame model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            n_m = 0;
            err_m = 1'b0;
            hold_v = 1'b0;
        end else begin
            exp_t e;
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            check("frame_err", 32'(frame_err), 32'(err_m));
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hold_d));
                check("stall_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_last", 32'(out_last), 32'(e.l));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            hold_l = out_last;
            if (in_valid && in_ready) begin
                e.d = mont_ref(in_data);
                e.l = in_last;
                exp_q.push_back(e);
                n_m++;
                if (in_last) begin
                    if (n_m != N) err_m = 1'b1;
                    n_m = 0;
                end else if (n_m == N) begin
                    err_m = 1'b1;
                    n_m = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic l);
        logic acc;
        in_valid = 1'b1;
        in_data  = a;
        in_last  = l;
        for (int k = 0; k < 200; k++) begin
            if (bp_mode) out_ready = ($urandom_range(0, 1) == 1);
            else out_ready = 1'b1;
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct { logic [15:0] a; logic [15:0] exp; } kv_t;
    kv_t kv[5];

    initial begin
        kv[0] = '{16'd0,     16'd0};
        kv[1] = '{16'd1,     16'd2285};
        kv[2] = '{16'd3328,  16'd1044};
        kv[3] = '{16'd3329,  16'd0};
        kv[4] = '{16'd65535, 16'd2397};

        #2;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Known values with exact three-edge latency.
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            in_data  = kv[i].a;
            in_last  = 1'b0;
            tick();
            in_valid = 1'b0;
            tick();
            check("kv_early_valid", 32'(out_valid), 32'd0);
            tick();
            check("kv_valid", 32'(out_valid), 32'd1);
            check("kv_data", 32'(out_data), 32'(kv[i].exp));
        end
        drain();
        do_reset();

        // Full frame, no stalls.
        out_cnt = 0;
        for (int i = 0; i < N; i++) send(16'(i), i == N - 1);
        drain();
        check("full_frame_count", 32'(out_cnt), 32'(N));
        check("full_frame_err", 32'(frame_err), 32'd0);

        // Random backpressure over two frames.
        bp_mode = 1'b1;
        out_cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            send(16'($urandom), (i % N) == N - 1);
            if ($urandom_range(0, 7) == 0) begin
                out_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        bp_mode = 1'b0;
        drain();
        check("bp_count", 32'(out_cnt), 32'(2 * N));
        check("bp_frame_err", 32'(frame_err), 32'd0);

        // Short frame, then a full frame still converts correctly.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom), i == 9);
            if (i == 8) check("short_err_before", 32'(frame_err), 32'd0);
            if (i == 9) check("short_err_after", 32'(frame_err), 32'd1);
        end
        for (int i = 0; i < N; i++) send(16'($urandom), i == N - 1);
        drain();
        check("short_err_sticky", 32'(frame_err), 32'd1);

        // Long frame: error after the 256th accept.
        do_reset();
        for (int i = 0; i <= N; i++) begin
            send(16'($urandom), i == N);
            if (i == N - 2) check("long_err_before", 32'(frame_err), 32'd0);
            if (i == N - 1) check("long_err_after", 32'(frame_err), 32'd1);
        end
        drain();

        // Reset with three beats in flight.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(7 + i);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_out", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 16'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'd2285);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
